// File: rtl/lab_tester_pkg.sv
// lab_tester_pkg: shared types and constants for the lab combinational-block testers
package lab_tester_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int NUM_VECTORS = 8;
    localparam logic [7:0] FA_SUM   = 8'b1001_0110;
    localparam logic [7:0] FA_CARRY = 8'b1110_1000;
endpackage

// File: rtl/settle_counter.sv
// settle_counter: counts 0..N-1 while enabled and flags the last count as the sample point
module settle_counter
    import lab_tester_pkg::*;
#(
    parameter int N = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    localparam int CW = $clog2(N + 1);
    logic [CW-1:0] r_cnt;
    assign tick = (r_cnt == CW'(N - 1));
    // Free count wraps to zero on the tick so the next vector starts its settle window cleanly
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (clear)
            r_cnt <= '0;
        else if (enable)
            r_cnt <= tick ? '0 : r_cnt + 1'b1;
    end
endmodule

// File: rtl/lab_vector_tester.sv
// lab_vector_tester: sweeps all eight {a,b,c} vectors and checks x/y against truth tables
module lab_vector_tester
    import lab_tester_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 10,
    parameter logic [7:0] EXP_X         = FA_SUM,
    parameter logic [7:0] EXP_Y         = FA_CARRY
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       x,
    input  logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [7:0] mismatch_map,
    output logic [2:0] first_fail,
    output logic       fail_seen
);
    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_vec;
    logic       r_done;
    logic       r_pass;
    logic       r_seen;
    logic [3:0] r_err;
    logic [7:0] r_map;
    logic [2:0] r_first;
    logic       w_tick;
    logic       w_start;
    logic       w_sample;
    logic       w_miss;
    logic       w_last;
    logic [3:0] w_err_next;

    assign w_start    = (r_state == IDLE) && start;
    assign w_sample   = (r_state == RUN) && w_tick;
    assign w_miss     = w_sample && ((x != EXP_X[r_vec]) || (y != EXP_Y[r_vec]));
    assign w_last     = w_sample && (r_vec == 3'(NUM_VECTORS - 1));
    assign w_err_next = r_err + {3'b000, w_miss};

    settle_counter #(.N(SETTLE_CYCLES)) u_settle (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_start),
        .enable (r_state == RUN),
        .tick   (w_tick)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Next state: DONE lasts one cycle and always falls back to IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? RUN : IDLE;
            RUN:     w_next = w_last ? DONE : RUN;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Vector register doubles as the stimulus; it wraps to 0 after vector 7 so a,b,c return low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vec   <= '0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_seen  <= 1'b0;
            r_err   <= '0;
            r_map   <= '0;
            r_first <= '0;
        end else begin
            r_done <= w_last;
            if (w_start) begin
                r_vec   <= '0;
                r_pass  <= 1'b0;
                r_seen  <= 1'b0;
                r_err   <= '0;
                r_map   <= '0;
                r_first <= '0;
            end else if (w_sample) begin
                r_vec <= r_vec + 3'd1;
                r_err <= w_err_next;
                if (w_miss) begin
                    r_map[r_vec] <= 1'b1;
                    if (!r_seen) begin
                        r_first <= r_vec;
                        r_seen  <= 1'b1;
                    end
                end
                if (w_last)
                    r_pass <= (w_err_next == 4'd0);
            end
        end
    end

    assign {a, b, c}    = r_vec;
    assign busy         = (r_state != IDLE);
    assign done         = r_done;
    assign pass         = r_pass;
    assign err_count    = r_err;
    assign mismatch_map = r_map;
    assign first_fail   = r_first;
    assign fail_seen    = r_seen;
endmodule

// File: tb/tb_lab_vector_tester.sv
// tb_lab_vector_tester: directed sweeps of the vector tester against modelled good and faulty adders
module tb_lab_vector_tester;
    localparam int S = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic       aa, ba, ca, xa, ya, busy_a, done_a, pass_a, seen_a;
    logic [3:0] err_a;
    logic [7:0] map_a;
    logic [2:0] first_a;
    logic       ab, bb, cb, xb, yb, busy_b, done_b, pass_b, seen_b;
    logic [3:0] err_b;
    logic [7:0] map_b;
    logic [2:0] first_b;
    int         mode = 0;
    logic       glitch = 1'b0;
    logic       any_done;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    // Block under test A: full adder, optionally x stuck at 0 or x glitched by the bench
    always_comb begin
        xa = (mode == 1) ? 1'b0 : ((aa ^ ba ^ ca) ^ glitch);
        ya = (aa & ba) | (aa & ca) | (ba & ca);
    end

    // Block under test B: full adder with carry inverted
    assign xb = ab ^ bb ^ cb;
    assign yb = ~((ab & bb) | (ab & cb) | (bb & cb));

    lab_vector_tester u_a (
        .clk(clk), .rst(rst), .start(start_a), .a(aa), .b(ba), .c(ca), .x(xa), .y(ya),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .mismatch_map(map_a), .first_fail(first_a), .fail_seen(seen_a)
    );

    lab_vector_tester #(.SETTLE_CYCLES(1)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .a(ab), .b(bb), .c(cb), .x(xb), .y(yb),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .mismatch_map(map_b), .first_fail(first_b), .fail_seen(seen_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sweep_a(input bit hold, input int gv, input logic [7:0] emap,
                           input logic [3:0] eerr, input logic [2:0] efirst);
        start_a = 1'b1;
        tick(1);
        if (!hold) start_a = 1'b0;
        chk("start_busy", 32'(busy_a), 1);
        chk("start_err_clr", 32'(err_a), 0);
        chk("start_map_clr", 32'(map_a), 0);
        chk("start_seen_clr", 32'(seen_a), 0);
        chk("start_pass_clr", 32'(pass_a), 0);
        for (int v = 0; v < 8; v++) begin
            if (v == gv) glitch = 1'b1;
            tick(S - 1);
            glitch = 1'b0;
            chk("abc_hold", 32'({aa, ba, ca}), v);
            chk("no_early_done", 32'(done_a), 0);
            tick(1);
        end
        chk("done", 32'(done_a), 1);
        chk("abc_end", 32'({aa, ba, ca}), 0);
        chk("err_count", 32'(err_a), 32'(eerr));
        chk("mismatch_map", 32'(map_a), 32'(emap));
        chk("first_fail", 32'(first_a), 32'(efirst));
        chk("fail_seen", 32'(seen_a), 32'(emap != 8'h00));
        chk("pass", 32'(pass_a), 32'(emap == 8'h00));
        tick(1);
        chk("done_one_cycle", 32'(done_a), 0);
        chk("back_idle", 32'(busy_a), 0);
        chk("err_held", 32'(err_a), 32'(eerr));
    endtask

    initial begin
        tick(2);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_done", 32'(done_a), 0);
        chk("rst_pass", 32'(pass_a), 0);
        chk("rst_err", 32'(err_a), 0);
        chk("rst_map", 32'(map_a), 0);
        chk("rst_first", 32'(first_a), 0);
        chk("rst_seen", 32'(seen_a), 0);
        chk("rst_abc", 32'({aa, ba, ca}), 0);
        @(negedge clk);
        rst = 1'b0;
        tick(2);
        // Good adder, then x stuck at 0
        sweep_a(1'b0, -1, 8'h00, 4'd0, 3'd0);
        mode = 1;
        sweep_a(1'b0, -1, 8'b1001_0110, 4'd4, 3'd1);
        mode = 0;
        // Held start: immediate restart two cycles after the done pulse, results cleared
        sweep_a(1'b1, -1, 8'h00, 4'd0, 3'd0);
        sweep_a(1'b1, -1, 8'h00, 4'd0, 3'd0);
        start_a = 1'b0;
        // Asynchronous reset while vector 4 is driven
        mode = 1;
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        tick(4 * S + 3);
        chk("pre_rst_abc", 32'({aa, ba, ca}), 4);
        chk("pre_rst_err", 32'(err_a), 2);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_abc", 32'({aa, ba, ca}), 0);
        chk("async_rst_busy", 32'(busy_a), 0);
        chk("async_rst_err", 32'(err_a), 0);
        chk("async_rst_map", 32'(map_a), 0);
        chk("async_rst_seen", 32'(seen_a), 0);
        #2 rst = 1'b0;
        mode = 0;
        any_done = 1'b0;
        for (int i = 0; i < 9 * S; i++) begin
            tick(1);
            any_done = any_done | done_a;
        end
        chk("no_done_after_rst", 32'(any_done), 0);
        chk("idle_after_rst", 32'(busy_a), 0);
        sweep_a(1'b0, -1, 8'h00, 4'd0, 3'd0);
        // x wrong between sample edges of vector 3 only
        sweep_a(1'b0, 3, 8'h00, 4'd0, 3'd0);
        // One-cycle settle, carry inverted
        start_b = 1'b1;
        tick(1);
        start_b = 1'b0;
        for (int v = 0; v < 8; v++) begin
            chk("b_abc", 32'({ab, bb, cb}), v);
            chk("b_no_early_done", 32'(done_b), 0);
            tick(1);
        end
        chk("b_done", 32'(done_b), 1);
        chk("b_err_count", 32'(err_b), 8);
        chk("b_map", 32'(map_b), 32'hFF);
        chk("b_first_fail", 32'(first_b), 0);
        chk("b_fail_seen", 32'(seen_b), 1);
        chk("b_pass", 32'(pass_b), 0);
        tick(1);
        chk("b_done_one_cycle", 32'(done_b), 0);
        chk("b_idle", 32'(busy_b), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
